// File: rtl/clk_div_pkg.sv
// Shared defaults, channel-select width helper and per-channel state record
// for the clk_div_bank divider bank.
package clk_div_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DIV_W_DEF    = 16;
    localparam int DEF_DIV_DEF  = 50000;

    // State fields are held at a fixed width so one record type serves any DIV_W
    // up to this limit; the unused upper bits stay zero and trim away.
    localparam int STATE_W = 32;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [STATE_W-1:0] d;
        logic [STATE_W-1:0] p;
        logic               pend;
        logic [STATE_W-1:0] cnt;
        logic               clk;
        logic               tick;
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor and glitch-free apply at wrap.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts the phase immediately.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [STATE_W-1:0] ONE     = STATE_W'(1);
    localparam logic [STATE_W-1:0] DEF_EXT = STATE_W'(DEF_DIV);
    localparam chan_state_t RST_ST = '{
        d: DEF_EXT, p: DEF_EXT, pend: 1'b0, cnt: '0, clk: 1'b0, tick: 1'b0
    };

    chan_state_t st, st_nxt;
    logic [STATE_W-1:0] wr_ext;

    assign wr_ext = STATE_W'(wr_div);

    always_comb begin
        st_nxt      = st;
        st_nxt.tick = 1'b0;
        if (st.d == '0) begin
            st_nxt.cnt = '0;
            st_nxt.clk = 1'b0;
            if (st.pend) begin
                st_nxt.d    = st.p;
                st_nxt.pend = 1'b0;
            end
        end else if (st.cnt == st.d - ONE) begin
            st_nxt.cnt  = '0;
            st_nxt.tick = 1'b1;
            if (st.pend) begin
                st_nxt.d    = st.p;
                st_nxt.pend = 1'b0;
                // Switching to a stopped divisor parks the clock low.
                st_nxt.clk  = (st.p != '0) && !st.clk;
            end else begin
                st_nxt.clk  = !st.clk;
            end
        end else begin
            st_nxt.cnt = st.cnt + ONE;
        end
        // A write on a wrap edge lands after the apply, so it waits for the next wrap.
        if (wr) begin
            st_nxt.p    = wr_ext;
            st_nxt.pend = 1'b1;
        end
`ifdef CLK_DIV_SYNC_EN
        if (sync) begin
            st_nxt.cnt  = '0;
            st_nxt.clk  = 1'b0;
            st_nxt.tick = 1'b0;
            st_nxt.d    = st.pend ? st.p : st.d;
            st_nxt.pend = 1'b0;
            if (wr) st_nxt.d = wr_ext;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= RST_ST;
        else       st <= st_nxt;
    end

    assign clk_o  = st.clk;
    assign tick_o = st.tick;
    assign pend_o = st.pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CHANNELS programmable clock dividers sharing one divisor write port.
// Define CLK_DIV_SYNC_EN to add the global sync (phase restart) input.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEF,
    parameter  int DIV_W    = DIV_W_DEF,
    parameter  int DEF_DIV  = DEF_DIV_DEF,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DIV_W-1:0]    wr_div,
`ifdef CLK_DIV_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] pend_o
);

    logic [CHANNELS-1:0] wr_sel;

    // Out-of-range channel numbers match no lane and are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .wr     (wr_sel[i]),
            .wr_div (wr_div),
`ifdef CLK_DIV_SYNC_EN
            .sync   (sync),
`endif
            .clk_o  (clk_o[i]),
            .tick_o (tick_o[i]),
            .pend_o (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: 3 channels, DEF_DIV = 5.
module tb_clk_div_bank;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [7:0]    wr_div = '0;
`ifdef CLK_DIV_SYNC_EN
    logic          sync = 1'b0;
`endif
    logic [CH-1:0] clk_o, tick_o, pend_o;

    typedef struct packed {
        logic [CH-1:0] tick;
        logic [CH-1:0] clk;
        logic [CH-1:0] pend;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    clk_div_bank #(.CHANNELS(CH), .DIV_W(8), .DEF_DIV(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
`ifdef CLK_DIV_SYNC_EN
        .sync   (sync),
`endif
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .pend_o (pend_o)
    );

    always #5 clk = ~clk;

    // Wrap count after k edges for a channel at divisor 5 that switches to d2 at wrap edge t.
    function automatic int seg(input int k, input int t, input int d2);
        return (k < t) ? k / 5 : t / 5 + (k - t) / d2;
    endfunction

    task automatic do_reset();
        wr_en = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        sync = 1'b0;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (clk_o !== 3'b000) begin failures++; $display("FAIL reset_clk got=%b exp=000", clk_o); end
        checks++;
        if (tick_o !== 3'b000) begin failures++; $display("FAIL reset_tick got=%b exp=000", tick_o); end
        checks++;
        if (pend_o !== 3'b000) begin failures++; $display("FAIL reset_pend got=%b exp=000", pend_o); end
    endtask

    task automatic test_default();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            e = '0;
            for (int c = 0; c < CH; c++) begin
                e.tick[c] = (k % 5 == 0);
                e.clk[c]  = ((k / 5) % 2 == 1);
            end
            sbq.push_back(e);
        end
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL default k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
    endtask

    task automatic test_write_mid();
        exp_t e;
        int w, wp;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            e = '0;
            for (int c = 0; c < CH; c++) begin
                w  = (c == 1) ? seg(k, 5, 2) : k / 5;
                wp = (c == 1) ? seg(k - 1, 5, 2) : (k - 1) / 5;
                e.tick[c] = (w != wp);
                e.clk[c]  = w[0];
            end
            e.pend[1] = (k >= 3 && k < 5);
            sbq.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            wr_en = (k == 3); wr_ch = 2'd1; wr_div = 8'd2;
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL write_mid k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_stop_restart();
        exp_t e;
        int w, wp;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            e = '0;
            e.tick[0] = (k % 5 == 0);
            e.clk[0]  = ((k / 5) % 2 == 1);
            w  = seg(k, 5, 1);
            wp = seg(k - 1, 5, 1);
            e.tick[1] = (w != wp);
            e.clk[1]  = w[0];
            e.pend[1] = (k >= 1 && k < 5);
            e.tick[2] = (k == 5) || (k == 10) || (k >= 17 && (k - 14) % 3 == 0);
            e.clk[2]  = (k >= 5 && k < 10) || (k >= 17 && ((k - 14) / 3) % 2 == 1);
            e.pend[2] = (k >= 7 && k < 10) || (k == 13);
            sbq.push_back(e);
        end
        for (int k = 1; k <= 25; k++) begin
            wr_en = 1'b0;
            case (k)
                1:  begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd1; end
                7:  begin wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd0; end
                13: begin wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd3; end
                default: ;
            endcase
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL stop_restart k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_edge_write();
        exp_t e;
        int w, wp;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            e = '0;
            w = seg(k, 10, 2); wp = seg(k - 1, 10, 2);
            e.tick[0] = (w != wp); e.clk[0] = w[0];
            e.pend[0] = (k >= 5 && k < 10);
            w = seg(k, 10, 3); wp = seg(k - 1, 10, 3);
            e.tick[1] = (w != wp); e.clk[1] = w[0];
            e.pend[1] = (k >= 6 && k < 10);
            e.tick[2] = (k % 5 == 0);
            e.clk[2]  = ((k / 5) % 2 == 1);
            sbq.push_back(e);
        end
        for (int k = 1; k <= 22; k++) begin
            wr_en = 1'b0;
            case (k)
                2: begin wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd1; end
                5: begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd2; end
                6: begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd4; end
                7: begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3; end
                default: ;
            endcase
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL edge_write k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            e = '0;
            for (int c = 0; c < CH; c++) begin
                e.tick[c] = (k % 5 == 0);
                e.clk[c]  = ((k / 5) % 2 == 1);
            end
            e.pend[0] = (k >= 6);
            sbq.push_back(e);
        end
        for (int k = 1; k <= 7; k++) begin
            wr_en = (k == 6); wr_ch = 2'd0; wr_div = 8'd2;
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({tick_o, clk_o, pend_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", {tick_o, clk_o, pend_o}, 9'b0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            e = '0;
            for (int c = 0; c < CH; c++) begin
                e.tick[c] = (k % 5 == 0);
                e.clk[c]  = ((k / 5) % 2 == 1);
            end
            sbq.push_back(e);
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        exp_t e;
        int j, d;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            e = '0;
            if (k < 4) begin
                for (int c = 0; c < CH; c++) begin
                    e.tick[c] = (k % 5 == 0);
                    e.clk[c]  = ((k / 5) % 2 == 1);
                end
                e.pend[0] = (k >= 2);
                e.pend[1] = (k == 3);
            end else begin
                j = k - 4;
                for (int c = 0; c < CH; c++) begin
                    d = (c == 0) ? 3 : 4;
                    e.tick[c] = (j > 0) && (j % d == 0);
                    e.clk[c]  = ((j / d) % 2 == 1);
                end
            end
            sbq.push_back(e);
        end
        for (int k = 1; k <= 18; k++) begin
            wr_en = 1'b0; sync = 1'b0;
            case (k)
                2: begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3; end
                3: begin wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd4; end
                4: begin wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd4; sync = 1'b1; end
                default: ;
            endcase
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({tick_o, clk_o, pend_o} !== e) begin
                failures++;
                $display("FAIL sync k=%0d got=%b exp=%b", k, {tick_o, clk_o, pend_o}, e);
            end
        end
        wr_en = 1'b0; sync = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_default();
        test_write_mid();
        test_stop_restart();
        test_edge_write();
        test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
